// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings, state type and lane helpers for the data-memory controller
package dm_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } dm_state_t;

    // Encoding 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return (lo != 2'b00);
        endcase
    endfunction

    // Bit offset of the selected little-endian lane inside the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return {lo[1], 4'b0000};
            SZ_BYTE: return {lo, 3'b000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - combinational lane extract/extend and sub-word merge
// Ports:
//   i_word   : word read from RAM
//   i_lo     : byte offset addr[1:0]
//   i_size   : normalised access size
//   i_sign   : 1 = sign-extend loads
//   i_wdata  : right-aligned store data
//   o_ext    : extracted and extended load value
//   o_merged : i_word with the store lane replaced by i_wdata
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ext,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_sh;
    logic [31:0] w_mask;

    assign w_shift = lane_shift(i_size, i_lo);
    assign w_sh    = i_word >> w_shift;

    always_comb begin
        o_ext  = i_word;
        w_mask = 32'hFFFF_FFFF;
        case (i_size)
            SZ_BYTE: begin
                o_ext  = {{24{i_sign & w_sh[7]}}, w_sh[7:0]};
                w_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                o_ext  = {{16{i_sign & w_sh[15]}}, w_sh[15:0]};
                w_mask = 32'h0000_FFFF;
            end
            default: begin
                o_ext  = i_word;
                w_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign o_merged = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

endmodule

// File: rtl/dm_rmw_ctrl.sv
// rtl/dm_rmw_ctrl.sv - CPU load/store to single-port RAM controller with sub-word read-modify-write
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req, we, addr,
//   wdata, MemByte,
//   lsign               : CPU request (sampled in IDLE only)
//   rdata, ack, stall,
//   err                 : CPU response; ack/err pulse one cycle in DONE
//   ram_addr, ram_we,
//   ram_din, ram_dout   : synchronous RAM port (one-cycle read latency)
module dm_rmw_ctrl
    import dm_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    MemByte,
    input  logic          lsign,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          stall,
    output logic          err,
    output logic [AW-3:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    dm_state_t     r_state, w_next;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_sign;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_merged;

    logic [1:0]    w_size;
    logic          w_mis;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_merged;

    assign w_size = norm_size(MemByte);
    assign w_mis  = is_misaligned(w_size, addr[1:0]);

    dm_lane_unit u_lane (
        .i_word   (ram_dout),
        .i_lo     (r_addr[1:0]),
        .i_size   (r_size),
        .i_sign   (r_sign),
        .i_wdata  (r_wdata),
        .o_ext    (w_ext),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_size   <= SZ_WORD;
            r_sign   <= 1'b0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_merged <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_addr  <= addr;
                        r_we    <= we;
                        r_size  <= w_size;
                        r_sign  <= lsign;
                        r_wdata <= wdata;
                        r_err   <= w_mis;
                        r_rdata <= '0;
                    end
                end
                ST_RD: begin
                    if (r_we) r_merged <= w_merged;
                    else      r_rdata  <= w_ext;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        ram_we   = 1'b0;
        ram_din  = '0;
        ram_addr = r_addr[AW-1:2];
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    // Drive the live address so the RAM sees it this cycle.
                    ram_addr = addr[AW-1:2];
                    if (w_mis) begin
                        w_next = ST_DONE;
                    end else if (we && (w_size == SZ_WORD)) begin
                        ram_we  = ~rst;
                        ram_din = wdata;
                        w_next  = ST_DONE;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:   w_next = r_we ? ST_WR : ST_DONE;
            ST_WR: begin
                // A reset arriving during WR abandons the write.
                ram_we  = ~rst;
                ram_din = r_merged;
                w_next  = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign ack   = (r_state == ST_DONE);
    assign err   = ack & r_err;
    assign stall = req & ~ack;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// tb/tb_dm_rmw_ctrl.sv - directed self-checking bench for dm_rmw_ctrl
module tb_dm_rmw_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  MemByte;
    logic        lsign;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        err;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:127];
    logic        pre_en;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;
    int          we_cnt;
    logic [31:0] last_din;

    dm_rmw_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .MemByte  (MemByte),
        .lsign    (lsign),
        .rdata    (rdata),
        .ack      (ack),
        .stall    (stall),
        .err      (err),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM model with a preload port and write logging.
    initial begin
        we_cnt   = 0;
        last_din = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            ram_dout <= mem[ram_addr];
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                we_cnt        <= we_cnt + 1;
                last_din      <= ram_din;
            end else if (pre_en) begin
                mem[pre_idx] <= pre_val;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        step();
        pre_en  = 1'b0;
    endtask

    // Issue one access; return ack latency (-1 on timeout), rdata/err at ack, stall cycles.
    task automatic access(input logic w, input logic [8:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic sg,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int stl);
        req = 1'b1; we = w; addr = a; wdata = d; MemByte = sz; lsign = sg;
        lat = -1; rd = 32'h0; er = 1'b0; stl = 0;
        #1;
        for (int k = 1; k <= 6; k++) begin
            if (stall) stl++;
            step();
            if (ack) begin
                lat = k;
                rd  = rdata;
                er  = err;
                break;
            end
        end
        req = 1'b0;
        step();
    endtask

    int          lat;
    int          stl;
    int          w0;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        MemByte = 2'b00; lsign = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        step();
        step();
        check("rst_ack",      {31'h0, ack},      32'h0);
        check("rst_err",      {31'h0, err},      32'h0);
        check("rst_rdata",    rdata,             32'h0);
        check("rst_ram_we",   {31'h0, ram_we},   32'h0);
        check("rst_ram_din",  ram_din,           32'h0);
        check("rst_ram_addr", {25'h0, ram_addr}, 32'h0);
        rst = 1'b0;
        preload(7'd8,  32'h1122_3344);
        preload(7'd12, 32'h8000_FF7F);
        preload(7'd1,  32'hCAFE_F00D);
        preload(7'd16, 32'h5566_7788);
        preload(7'd20, 32'h0BAD_CAFE);

        // Word store then word load.
        w0 = we_cnt;
        access(1'b1, 9'h010, 32'hDEAD_BEEF, 2'b00, 1'b0, lat, rd, er, stl);
        check("wst_lat",    lat,          32'd1);
        check("wst_we_cnt", we_cnt - w0,  32'd1);
        check("wst_mem",    mem[4],       32'hDEAD_BEEF);
        access(1'b0, 9'h010, 32'h0, 2'b00, 1'b0, lat, rd, er, stl);
        check("wld_lat",    lat,          32'd2);
        check("wld_rdata",  rd,           32'hDEAD_BEEF);
        check("wld_we_cnt", we_cnt - w0,  32'd1);

        // Byte store read-modify-write.
        w0 = we_cnt;
        access(1'b1, 9'h022, 32'h0000_00AA, 2'b10, 1'b0, lat, rd, er, stl);
        check("bst_lat",    lat,          32'd3);
        check("bst_stall",  stl,          32'd3);
        check("bst_we_cnt", we_cnt - w0,  32'd1);
        check("bst_din",    last_din,     32'h11AA_3344);
        check("bst_mem",    mem[8],       32'h11AA_3344);

        // Lane extraction and extension.
        access(1'b0, 9'h030, 32'h0, 2'b10, 1'b1, lat, rd, er, stl);
        check("lb_s0",      rd,           32'h0000_007F);
        access(1'b0, 9'h031, 32'h0, 2'b10, 1'b1, lat, rd, er, stl);
        check("lb_s1",      rd,           32'hFFFF_FFFF);
        access(1'b0, 9'h032, 32'h0, 2'b01, 1'b0, lat, rd, er, stl);
        check("lh_u2",      rd,           32'h0000_8000);
        access(1'b0, 9'h032, 32'h0, 2'b01, 1'b1, lat, rd, er, stl);
        check("lh_s2",      rd,           32'hFFFF_8000);
        check("lh_s2_lat",  lat,          32'd2);

        // Halfword store into the upper lane.
        access(1'b1, 9'h052, 32'h1234_BEEF, 2'b01, 1'b0, lat, rd, er, stl);
        check("hst_mem",    mem[20],      32'hBEEF_CAFE);

        // Misaligned accesses.
        w0 = we_cnt;
        access(1'b0, 9'h005, 32'h0, 2'b00, 1'b0, lat, rd, er, stl);
        check("mis_ld_lat",   lat,          32'd1);
        check("mis_ld_err",   {31'h0, er},  32'h1);
        check("mis_ld_rdata", rd,           32'h0);
        access(1'b1, 9'h007, 32'h0000_1234, 2'b01, 1'b0, lat, rd, er, stl);
        check("mis_st_lat",   lat,          32'd1);
        check("mis_st_err",   {31'h0, er},  32'h1);
        check("mis_we_cnt",   we_cnt - w0,  32'd0);
        check("mis_mem",      mem[1],       32'hCAFE_F00D);
        access(1'b0, 9'h004, 32'h0, 2'b00, 1'b0, lat, rd, er, stl);
        check("al_ld_err",    {31'h0, er},  32'h0);
        check("al_ld_rdata",  rd,           32'hCAFE_F00D);

        // Reset during WR of a byte store.
        w0 = we_cnt;
        req = 1'b1; we = 1'b1; addr = 9'h041; wdata = 32'h99; MemByte = 2'b10; lsign = 1'b0;
        step();
        step();
        check("rwr_in_wr",    {31'h0, ram_we}, 32'h1);
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("rwr_gate_we",  {31'h0, ram_we}, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("rwr_ack",      {31'h0, ack},    32'h0);
        check("rwr_ram_we",   {31'h0, ram_we}, 32'h0);
        step();
        check("rwr_we_cnt",   we_cnt - w0,     32'd0);
        check("rwr_mem",      mem[16],         32'h5566_7788);
        access(1'b0, 9'h040, 32'h0, 2'b00, 1'b0, lat, rd, er, stl);
        check("rwr_post_lat", lat,             32'd2);
        check("rwr_post_rd",  rd,              32'h5566_7788);

        // Back-to-back loads with req held high.
        req = 1'b1; we = 1'b0; addr = 9'h010; MemByte = 2'b00; lsign = 1'b0;
        step();
        check("b2b_c1_ack",   {31'h0, ack},    32'h0);
        step();
        check("b2b_c2_ack",   {31'h0, ack},    32'h1);
        check("b2b_c2_rd",    rdata,           32'hDEAD_BEEF);
        addr = 9'h030;
        step();
        check("b2b_c3_ack",   {31'h0, ack},    32'h0);
        step();
        check("b2b_c4_ack",   {31'h0, ack},    32'h0);
        step();
        check("b2b_c5_ack",   {31'h0, ack},    32'h1);
        check("b2b_c5_rd",    rdata,           32'h8000_FF7F);
        req = 1'b0;
        step();
        check("b2b_end_ack",  {31'h0, ack},    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_rmw_ctrl.md
Name: dm_rmw_ctrl

Overview:
- Data-memory access controller between the CPU load/store port and a word-wide synchronous single-port RAM.
- Performs byte, halfword and word accesses.
- Sub-word stores use a read-modify-write sequence; a word store is a single write.
- Handles load lane extraction and sign/zero extension, and flags misaligned accesses.
- Stalls the CPU through a req/ack handshake.

Parameters:
- AW, 9, byte-address width; the RAM has 2^(AW-2) words.
- DW, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req  in  1  access request, held high until ack
- we  in  1  1=store, 0=load; sampled in IDLE
- addr  in  AW  byte address
- wdata  in  32  store data, right-aligned
- MemByte  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
- lsign  in  1  loads: 1=sign-extend, 0=zero-extend
- rdata  out  32  load result, extended; valid while ack=1
- ack  out  1  one-cycle completion pulse
- stall  out  1  req & ~ack, to CPU PC/pipeline hold
- err  out  1  misalign flag, pulses together with ack
- ram_addr  out  AW-2  word address = addr[AW-1:2]
- ram_we  out  1  RAM write enable
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid one cycle after address

Behaviour:
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; halfword addr[1]=0 selects bits 15:0.
- Reset values: state=IDLE, rdata=0, ack=0, err=0, ram_we=0, ram_din=0. ram_addr follows the latched address register, which is 0 at reset.
- States: IDLE, RD, WR, DONE.
- IDLE, req=0: remain in IDLE; ram_we=0.
- IDLE, req=1: latch addr, we, MemByte, lsign and wdata. Then:
  - Misaligned (word with addr[1:0]!=0, or halfword with addr[0]=1): go to DONE with err=1; no RAM write occurs; rdata=0.
  - Word store: ram_we=1 combinationally this cycle with ram_din=wdata; go to DONE. Total latency: ack in cycle 1.
  - Load or sub-word store: present the read address this cycle; go to RD.
- RD: capture ram_dout.
  - Load: extract the lane, extend per lsign, register into rdata; go to DONE. Latency: ack in cycle 2.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of the captured word; go to WR.
- WR: ram_we=1 with ram_din = merged word; go to DONE. Latency: ack in cycle 3.
- DONE: ack=1 and err per latched result; rdata held; go to IDLE.
- CPU obligations:
  - The CPU must deassert req, or present a new request, in the cycle after ack.
  - A req still high in IDLE starts a new access.
- req dropped mid-operation: the operation still completes and ack still pulses. The request inputs are ignored outside IDLE.
- Reset mid-operation: on the next edge return to IDLE with all outputs at reset values. A pending WR is abandoned and the RAM is not written.
- ram_we is never asserted in RD or DONE, and never for an erroring access.
- Address wrap: only addr[AW-1:2] reaches the RAM; upper bits of the CPU address are discarded by the top level.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - the state enum;
  - the lane-select helper functions.
- One natural sub-module, dm_lane_unit (combinational). It performs lane extraction with extension and the sub-word merge, so the same logic serves both load and RMW paths.

Test Plan:
- Word store of 0xDEADBEEF at addr 0x010, then word load at 0x010 -> ack on cycles 1 and 2 respectively; rdata=0xDEADBEEF; exactly one ram_we pulse.
- RAM word 0x11223344 at 0x020; byte store 0xAA at 0x022 -> ram_we only in WR, ram_din=0x11AA3344, ack in cycle 3, stall high for 3 cycles.
- RAM word 0x8000FF7F at 0x030:
  - signed byte load at 0x030 -> 0x0000007F;
  - signed byte load at 0x031 -> 0xFFFFFFFF;
  - unsigned halfword load at 0x032 -> 0x00008000;
  - signed halfword load at 0x032 -> 0xFFFF8000.
- Word load at 0x005 and halfword store at 0x007 -> err=1 together with ack in cycle 1; ram_we never asserted; RAM contents unchanged.
- Assert rst during WR of a byte store -> next cycle state IDLE, ack=0, ram_we=0, target word unchanged.
- Back-to-back requests: req held continuously across two loads -> second access begins in the IDLE cycle following DONE; two distinct ack pulses with correct rdata each.
